// File: rtl/race_timer_ctrl.sv
// race_timer_ctrl: round sequencer for the typing race.
// Runs IDLE -> COUNTDOWN -> RUNNING (<-> PAUSED) -> DONE, driven by an external
// 100 Hz tick. It drives the countdown/elapsed display values and gates typing input.
module race_timer_ctrl #(
    parameter int TICKS_PER_SEC = 100,
    parameter int COUNTDOWN_SEC = 3,
    parameter int LIMIT_SEC     = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       finish,
    output logic [2:0] state,
    output logic [3:0] countdown_val,
    output logic [6:0] elapsed_cs,
    output logic [6:0] elapsed_sec,
    output logic       input_en,
    output logic       timeout,
    output logic       done_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [6:0] TPS_LAST = 7'(TICKS_PER_SEC - 1);
    localparam logic [3:0] CD_INIT  = 4'(COUNTDOWN_SEC);
    localparam logic [6:0] LIMIT    = 7'(LIMIT_SEC);

    state_t     state_q, state_d;
    logic [3:0] cd_q, cd_d;
    logic [6:0] sub_q, sub_d;
    logic [6:0] cs_q, cs_d;
    logic [6:0] sec_q, sec_d;
    logic       timeout_q, timeout_d;
    logic       done_pulse_q, done_pulse_d;
    logic       input_en_q, input_en_d;

    // Next-state and next-output logic; finish outranks pause, pause outranks tick.
    always_comb begin
        state_d      = state_q;
        cd_d         = cd_q;
        sub_d        = sub_q;
        cs_d         = cs_q;
        sec_d        = sec_q;
        timeout_d    = timeout_q;
        done_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_COUNTDOWN;
                    cd_d      = CD_INIT;
                    sub_d     = '0;
                    cs_d      = '0;
                    sec_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (sub_q == TPS_LAST) begin
                        sub_d = '0;
                        if (cd_q == 4'd1) begin
                            state_d = ST_RUNNING;
                            cd_d    = '0;
                            cs_d    = '0;
                            sec_d   = '0;
                        end else begin
                            cd_d = cd_q - 4'd1;
                        end
                    end else begin
                        sub_d = sub_q + 7'd1;
                    end
                end
            end
            ST_RUNNING: begin
                if (finish) begin
                    state_d      = ST_DONE;
                    timeout_d    = 1'b0;
                    done_pulse_d = 1'b1;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (tick) begin
                    if (cs_q == TPS_LAST) begin
                        cs_d  = '0;
                        sec_d = sec_q + 7'd1;
                        if (sec_q + 7'd1 == LIMIT) begin
                            state_d      = ST_DONE;
                            timeout_d    = 1'b1;
                            done_pulse_d = 1'b1;
                        end
                    end else begin
                        cs_d = cs_q + 7'd1;
                    end
                end
            end
            ST_PAUSED: begin
                if (pause) begin
                    state_d = ST_RUNNING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        input_en_d = (state_d == ST_RUNNING);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cd_q         <= '0;
            sub_q        <= '0;
            cs_q         <= '0;
            sec_q        <= '0;
            timeout_q    <= 1'b0;
            done_pulse_q <= 1'b0;
            input_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cd_q         <= cd_d;
            sub_q        <= sub_d;
            cs_q         <= cs_d;
            sec_q        <= sec_d;
            timeout_q    <= timeout_d;
            done_pulse_q <= done_pulse_d;
            input_en_q   <= input_en_d;
        end
    end

    assign state         = state_q;
    assign countdown_val = cd_q;
    assign elapsed_cs    = cs_q;
    assign elapsed_sec   = sec_q;
    assign input_en      = input_en_q;
    assign timeout       = timeout_q;
    assign done_pulse    = done_pulse_q;

endmodule

// File: tb/tb_race_timer_ctrl.sv
// tb_race_timer_ctrl: directed plus randomized stimulus against a tick-counting model.
module tb_race_timer_ctrl;

    localparam int TPS   = 4;
    localparam int CDS   = 3;
    localparam int LIM   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       finish = 1'b0;
    logic [2:0] state;
    logic [3:0] countdown_val;
    logic [6:0] elapsed_cs;
    logic [6:0] elapsed_sec;
    logic       input_en;
    logic       timeout;
    logic       done_pulse;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: phase, countdown ticks consumed, race ticks counted.
    int m_mode  = 0;
    int m_ctick = 0;
    int m_rt    = 0;
    int m_to    = 0;
    int m_dp    = 0;

    race_timer_ctrl #(
        .TICKS_PER_SEC(TPS),
        .COUNTDOWN_SEC(CDS),
        .LIMIT_SEC(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .start(start),
        .pause(pause),
        .finish(finish),
        .state(state),
        .countdown_val(countdown_val),
        .elapsed_cs(elapsed_cs),
        .elapsed_sec(elapsed_sec),
        .input_en(input_en),
        .timeout(timeout),
        .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge from the inputs it sampled.
    always @(posedge clk) begin
        int mode, ct, rt, to, dp;
        mode = m_mode; ct = m_ctick; rt = m_rt; to = m_to; dp = 0;
        if (rst) begin
            mode = 0; ct = 0; rt = 0; to = 0;
        end else begin
            case (mode)
                0, 4: if (start) begin mode = 1; ct = 0; rt = 0; to = 0; end
                1: if (tick) begin
                       ct++;
                       if (ct == CDS * TPS) begin mode = 2; rt = 0; end
                   end
                2: if (finish) begin mode = 4; to = 0; dp = 1; end
                   else if (pause) mode = 3;
                   else if (tick) begin
                       rt++;
                       if (rt == LIM * TPS) begin mode = 4; to = 1; dp = 1; end
                   end
                3: if (pause) mode = 2;
                default: mode = 0;
            endcase
        end
        m_mode  <= mode;
        m_ctick <= ct;
        m_rt    <= rt;
        m_to    <= to;
        m_dp    <= dp;
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_state", int'(state), m_mode);
            chk("m_countdown", int'(countdown_val), (m_mode == 1) ? CDS - m_ctick / TPS : 0);
            chk("m_cs", int'(elapsed_cs), m_rt % TPS);
            chk("m_sec", int'(elapsed_sec), m_rt / TPS);
            chk("m_input_en", int'(input_en), (m_mode == 2) ? 1 : 0);
            chk("m_timeout", int'(timeout), m_to);
            chk("m_done_pulse", int'(done_pulse), m_dp);
        end
    end

    task automatic pulse(input bit tk, input bit st, input bit ps, input bit fn);
        @(negedge clk);
        tick = tk; start = st; pause = ps; finish = fn;
        @(negedge clk);
        tick = 1'b0; start = 1'b0; pause = 1'b0; finish = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_cd"}, int'(countdown_val), 0);
        chk({tag, "_cs"}, int'(elapsed_cs), 0);
        chk({tag, "_sec"}, int'(elapsed_sec), 0);
        chk({tag, "_en"}, int'(input_en), 0);
        chk({tag, "_to"}, int'(timeout), 0);
        chk({tag, "_dp"}, int'(done_pulse), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk_all_zero("reset");
        tick_n(20);
        chk_all_zero("idle_ticks");

        // Countdown
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("cd_start_state", int'(state), 1);
        chk("cd_start_val", int'(countdown_val), 3);
        tick_n(4);
        chk("cd_after4", int'(countdown_val), 2);
        tick_n(4);
        chk("cd_after8", int'(countdown_val), 1);
        tick_n(4);
        chk("cd_after12_state", int'(state), 2);
        chk("cd_after12_val", int'(countdown_val), 0);
        chk("cd_after12_en", int'(input_en), 1);
        chk("cd_after12_cs", int'(elapsed_cs), 0);
        chk("cd_after12_sec", int'(elapsed_sec), 0);

        // Timeout
        tick_n(7);
        chk("to7_sec", int'(elapsed_sec), 1);
        chk("to7_cs", int'(elapsed_cs), 3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("to8_state", int'(state), 4);
        chk("to8_sec", int'(elapsed_sec), 2);
        chk("to8_cs", int'(elapsed_cs), 0);
        chk("to8_timeout", int'(timeout), 1);
        chk("to8_dp", int'(done_pulse), 1);
        chk("to8_en", int'(input_en), 0);
        @(negedge clk);
        chk("to8_dp_drop", int'(done_pulse), 0);
        chk("to8_hold_sec", int'(elapsed_sec), 2);

        // Restart from DONE
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rs_state", int'(state), 1);
        chk("rs_cd", int'(countdown_val), 3);
        chk("rs_to", int'(timeout), 0);
        chk("rs_cs", int'(elapsed_cs), 0);
        chk("rs_sec", int'(elapsed_sec), 0);

        // Finish colliding with a tick
        tick_n(12);
        tick_n(2);
        chk("fc_pre_cs", int'(elapsed_cs), 2);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        chk("fc_state", int'(state), 4);
        chk("fc_cs", int'(elapsed_cs), 2);
        chk("fc_sec", int'(elapsed_sec), 0);
        chk("fc_to", int'(timeout), 0);
        chk("fc_dp", int'(done_pulse), 1);

        // Pause
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(12);
        tick_n(5);
        chk("pz_pre_sec", int'(elapsed_sec), 1);
        chk("pz_pre_cs", int'(elapsed_cs), 1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pz_state", int'(state), 3);
        chk("pz_en", int'(input_en), 0);
        tick_n(10);
        chk("pz_hold_sec", int'(elapsed_sec), 1);
        chk("pz_hold_cs", int'(elapsed_cs), 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pz_finish_ign", int'(state), 3);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        chk("pz_resume", int'(state), 2);
        chk("pz_resume_cs", int'(elapsed_cs), 1);
        tick_n(1);
        chk("pz_post_sec", int'(elapsed_sec), 1);
        chk("pz_post_cs", int'(elapsed_cs), 2);

        // Mid-countdown reset
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(4);
        chk("mr_cd", int'(countdown_val), 2);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; tick = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; tick = 1'b0;
        chk_all_zero("midreset");

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            tick   = ($urandom_range(2, 0) == 0);
            start  = ($urandom_range(19, 0) == 0);
            pause  = ($urandom_range(14, 0) == 0);
            finish = ($urandom_range(39, 0) == 0);
            rst    = ($urandom_range(399, 0) == 0);
        end
        @(negedge clk);
        tick = 1'b0; start = 1'b0; pause = 1'b0; finish = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/race_timer_ctrl.md
Name: race_timer_ctrl

Overview:
- Sequences the game timing for a TypeRacer round: idle, pre-race countdown, timed race, optional pause, then finished.
- Consumes the one-cycle 100 Hz tick from the existing centisecond divider; keeps no prescaler of its own.
- Drives the display (countdown digit, elapsed seconds and centiseconds) and gates keyboard input to the typing datapath.

Parameters:
- TICKS_PER_SEC, 100, tick pulses per second; legal range 2..127.
- COUNTDOWN_SEC, 3, length of the pre-race countdown in seconds; legal range 1..15.
- LIMIT_SEC, 60, race time limit in seconds; legal range 1..127.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse at 100 Hz from the divider.
- start  in  1  one-cycle pulse (debounced button).
- pause  in  1  one-cycle pulse; toggles pause.
- finish  in  1  one-cycle pulse from the typing logic when the last character is typed correctly.
- state  out  3  0=IDLE, 1=COUNTDOWN, 2=RUNNING, 3=PAUSED, 4=DONE.
- countdown_val  out  4  seconds remaining in COUNTDOWN; 0 in every other state.
- elapsed_cs  out  7  sub-second count, 0..TICKS_PER_SEC-1.
- elapsed_sec  out  7  whole seconds elapsed in the race.
- input_en  out  1  high only in RUNNING.
- timeout  out  1  high in DONE when the limit ended the race.
- done_pulse  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE; countdown_val, elapsed_cs, elapsed_sec = 0; input_en, timeout, done_pulse = 0.
  - The internal sub-second counter is 0.
- rst asserted mid-operation overrides every other input on that edge.

IDLE:
- start: next state COUNTDOWN; countdown_val=COUNTDOWN_SEC, sub=0, elapsed_cs=0, elapsed_sec=0, timeout=0.
- Ticks, pause and finish are ignored.

COUNTDOWN:
- Each tick: sub+1.
- When sub==TICKS_PER_SEC-1 and tick: sub=0 and countdown_val-1.
- If countdown_val was 1 on that tick: next state RUNNING, countdown_val=0, elapsed cleared.
- Total duration is exactly COUNTDOWN_SEC*TICKS_PER_SEC ticks.
- start, pause and finish are ignored.

RUNNING:
- Each tick: elapsed_cs+1.
- At TICKS_PER_SEC-1, elapsed_cs wraps to 0 and elapsed_sec increments.
- When an increment produces elapsed_sec==LIMIT_SEC (elapsed_cs=0):
  - next state DONE, timeout=1, done_pulse=1.
- finish: next state DONE, timeout=0, done_pulse=1; elapsed values freeze at their current values.
- pause: next state PAUSED.
- start is ignored.

PAUSED:
- Ticks are ignored; elapsed values hold.
- pause returns to RUNNING.
- finish, start and tick are all ignored.

DONE:
- elapsed_* and timeout hold.
- start behaves exactly as start in IDLE (restart into COUNTDOWN, timeout cleared).
- pause and finish are ignored.

Simultaneous events, in priority order (highest first):
1. rst
2. finish
3. pause
4. tick
- finish together with a tick in RUNNING: the tick is not counted.
- finish together with the limit-reaching tick: DONE with timeout=0.
- pause together with a tick in RUNNING: PAUSED, and the tick is not counted.

Other rules:
- done_pulse is high for exactly the one cycle in which state first reads DONE.
- Widths: all counters compare with equality and never exceed their ranges; no saturation logic is needed beyond the LIMIT_SEC stop.

Test Plan:
(Parameters for the bench: TICKS_PER_SEC=4, COUNTDOWN_SEC=3, LIMIT_SEC=2; tick every 5 cycles unless stated.)
- Reset then idle: drive 20 ticks with no start -> state=0, all outputs 0.
- Countdown: start, then ticks.
  - countdown_val reads 3 after start, 2 after 4 ticks, 1 after 8 ticks.
  - After the 12th tick: state=2, countdown_val=0, input_en=1, elapsed 0:0.
- Timeout: from RUNNING, 8 ticks.
  - After the 7th tick: elapsed 1:3.
  - After the 8th tick: state=4, elapsed 2:0, timeout=1, done_pulse high for 1 cycle, input_en=0.
- Finish/tick collision: from RUNNING at elapsed 0:2, assert finish on the same cycle as a tick -> state=4, elapsed 0:2, timeout=0.
- Pause: from RUNNING at 1:1, pulse pause, drive 10 ticks, pulse pause again, then 1 tick.
  - Elapsed reads 1:1 throughout the pause and 1:2 after the final tick.
  - finish while PAUSED has no effect.
- Restart and mid-run reset:
  - In DONE, pulse start -> state=1, countdown_val=3, timeout=0, elapsed 0:0.
  - Assert rst during COUNTDOWN at countdown_val=2 -> IDLE with all outputs 0 on the next cycle.
